// File: rtl/shift_sequencer.sv
// ARM operand-2 shifter, one bit per clock: LSL/LSR/ASR/ROR and the immediate-rotate form.
// Latency k+1 cycles (max 34) from acceptance to rsp_valid; the response is held in DONE while rsp_ready is low.
module shift_sequencer #(
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      operand,
    input  logic [AMT_W-1:0] amount,
    input  logic [1:0]       shift_type,
    input  logic             imm_rot,
    input  logic             cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      result,
    output logic             cout,
    output logic             busy
);

    localparam logic [1:0] T_LSL = 2'b00;
    localparam logic [1:0] T_LSR = 2'b01;
    localparam logic [1:0] T_ASR = 2'b10;
    localparam logic [1:0] T_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_work;
    logic        r_cout;
    logic [5:0]  r_cnt;
    logic [1:0]  r_type;

    logic        w_accept;
    logic [1:0]  w_type;
    logic [5:0]  w_k;
    logic        w_cout_init;
    logic [5:0]  w_amt_sat33;
    logic [5:0]  w_amt_sat32;
    logic [31:0] w_step_work;
    logic        w_step_cout;

    assign w_accept = req_valid && req_ready;

    // Saturating the count at 33 (32 for ASR) lets the plain one-bit iteration
    // produce the ARM results for large amounts without any special-case logic.
    always_comb begin
        w_amt_sat33 = amount[5:0];
        w_amt_sat32 = amount[5:0];
        if (amount > AMT_W'(33)) begin
            w_amt_sat33 = 6'd33;
        end
        if (amount > AMT_W'(32)) begin
            w_amt_sat32 = 6'd32;
        end
    end

    always_comb begin
        w_type      = imm_rot ? T_ROR : shift_type;
        w_k         = 6'd0;
        w_cout_init = cin;
        if (imm_rot) begin
            w_k = {1'b0, amount[3:0], 1'b0};
        end else if (amount != '0) begin
            case (shift_type)
                T_LSL, T_LSR: w_k = w_amt_sat33;
                T_ASR:        w_k = w_amt_sat32;
                default: begin
                    w_k = {1'b0, amount[4:0]};
                    // Register ROR by a nonzero multiple of 32: value unchanged, carry = bit 31.
                    if (amount[4:0] == 5'd0) begin
                        w_cout_init = operand[31];
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_step_work = r_work;
        w_step_cout = r_cout;
        case (r_type)
            T_LSL: begin
                w_step_cout = r_work[31];
                w_step_work = {r_work[30:0], 1'b0};
            end
            T_LSR: begin
                w_step_cout = r_work[0];
                w_step_work = {1'b0, r_work[31:1]};
            end
            T_ASR: begin
                w_step_cout = r_work[0];
                w_step_work = {r_work[31], r_work[31:1]};
            end
            default: begin
                w_step_cout = r_work[0];
                w_step_work = {r_work[0], r_work[31:1]};
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (w_k != 6'd0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == 6'd1) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        rsp_valid = (r_state == S_DONE);
        busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= 32'd0;
            r_cout <= 1'b0;
            r_cnt  <= 6'd0;
            r_type <= T_LSL;
        end else if (w_accept) begin
            r_work <= operand;
            r_cout <= w_cout_init;
            r_cnt  <= w_k;
            r_type <= w_type;
        end else if (r_state == S_SHIFT) begin
            r_work <= w_step_work;
            r_cout <= w_step_cout;
            r_cnt  <= r_cnt - 6'd1;
        end
    end

    assign result = r_work;
    assign cout   = r_cout;

endmodule
